// File: rtl/score_arbiter.sv
// score_arbiter: round-robin share of one Score unit among NREQ Minmax leaves; SCORE_ARB_TIMEOUT_EN adds an S_WAIT abort.
// Latency: request seen in idle -> o_sc_start next cycle; i_sc_finish -> o_done next cycle.
// Backpressure: requesters hold i_req until their o_done; the Score unit is never stalled.
module score_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*450-1:0]  i_board,
  input  logic [NREQ-1:0]      i_turn,
  output logic [NREQ-1:0]      o_done,
  output logic signed [31:0]   o_score,
  output logic                 o_sc_start,
  output logic [449:0]         o_sc_board,
  output logic                 o_sc_turn,
  input  logic                 i_sc_finish,
  input  logic signed [31:0]   i_sc_score,
  output logic                 o_busy,
  output logic                 o_timeout
);
  localparam int GW = $clog2(NREQ);
  localparam logic signed [31:0] MINN = 32'sh80000001;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      grant, last_grant, pick_idx;
  logic               mask_vld, pick_vld, wait_expired;
  logic [NREQ-1:0]    elig, done_nxt;
  logic signed [31:0] score_nxt;
  logic               start_nxt, busy_nxt;
  logic [449:0]       pick_board;
  logic               pick_turn;

  // The just-served requester sits out exactly one idle cycle.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = i_req[k] && !(mask_vld && (last_grant == GW'(k)));
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pick_vld && elig[k] && (((int'(last_grant) + i) % NREQ) == k)) begin
          pick_vld = 1'b1;
          pick_idx = GW'(k);
        end
      end
    end
  end

  always_comb begin
    pick_board = '0;
    pick_turn  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == GW'(k)) begin
        pick_board = i_board[k*450 +: 450];
        pick_turn  = i_turn[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (i_sc_finish || wait_expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_nxt = (state == S_IDLE) && pick_vld;
    done_nxt  = '0;
    score_nxt = o_score;
    if (state == S_WAIT) begin
      if (i_sc_finish) begin
        done_nxt  = NREQ'(1) << grant;
        score_nxt = i_sc_score;
      end else if (wait_expired) begin
        done_nxt  = NREQ'(1) << grant;
        score_nxt = MINN;
      end
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      mask_vld   <= 1'b0;
      o_sc_board <= '0;
      o_sc_turn  <= 1'b0;
      o_sc_start <= 1'b0;
      o_done     <= '0;
      o_score    <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_sc_start <= start_nxt;
      o_done     <= done_nxt;
      o_score    <= score_nxt;
      o_busy     <= busy_nxt;
      mask_vld   <= (state == S_DONE);
      if (start_nxt) begin
        grant      <= pick_idx;
        o_sc_board <= pick_board;
        o_sc_turn  <= pick_turn;
      end
      if (state == S_DONE) last_grant <= grant;
    end
  end

`ifdef SCORE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      wait_cnt  <= (state == S_WAIT) ? wait_cnt + CW'(1) : '0;
      o_timeout <= (state == S_WAIT) && !i_sc_finish && wait_expired;
    end
  end

  // Counts S_WAIT cycles from 0, so the abort fires on the TIMEOUT-th one.
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
`else
  // No abort without the counter; TIMEOUT is always positive, so this folds to 0.
  assign wait_expired = (TIMEOUT < 0);
  assign o_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_score_arbiter.sv
// Bench for score_arbiter: directed scenarios plus randomized request traffic against a round-robin queue model.
module tb_score_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic [NREQ-1:0]     i_req;
  logic [NREQ*450-1:0] i_board;
  logic [NREQ-1:0]     i_turn;
  logic [NREQ-1:0]     o_done;
  logic signed [31:0]  o_score;
  logic                o_sc_start;
  logic [449:0]        o_sc_board;
  logic                o_sc_turn;
  logic                i_sc_finish;
  logic signed [31:0]  i_sc_score;
  logic                o_busy;
  logic                o_timeout;

  int checks;
  int failures;

  score_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_board(i_board), .i_turn(i_turn),
    .o_done(o_done), .o_score(o_score), .o_sc_start(o_sc_start), .o_sc_board(o_sc_board),
    .o_sc_turn(o_sc_turn), .i_sc_finish(i_sc_finish), .i_sc_score(i_sc_score),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [449:0] obs, input logic [449:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [449:0] rand450();
    logic [479:0] v;
    for (int i = 0; i < 15; i++) v[i*32 +: 32] = $urandom;
    return v[449:0];
  endfunction

  // First requester strictly after 'from' in circular order.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int from);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(from + i) % NREQ]) return (from + i) % NREQ;
    end
    return -1;
  endfunction

  // Serve one evaluation: expect requester k granted 'gap' cycles from now,
  // respond 'lat' cycles after o_sc_start with score sc.
  task automatic run_one(input int k, input int gap, input int lat, input logic [31:0] sc,
                         input bit fin_start, input bit drop);
    int n;
    logic [449:0] eb;
    logic et;
    eb = i_board[k*450 +: 450];
    et = i_turn[k];
    n  = 0;
    do begin
      step();
      n++;
      chk("done_idle", 450'(o_done), 450'(0));
    end while (!o_sc_start && n < 20);
    chk("start_gap", 450'(n), 450'(gap));
    chk("sc_board", o_sc_board, eb);
    chk("sc_turn", 450'(o_sc_turn), 450'(et));
    chk("busy_start", 450'(o_busy), 450'(1));
    i_board[k*450 +: 450] = rand450();
    i_turn[k] = ~i_turn[k];
    if (drop) i_req[k] = 1'b0;
    if (fin_start) begin
      i_sc_finish = 1'b1;
      i_sc_score  = 32'hDEAD_BEEF;
    end
    for (int c = 0; c < lat; c++) begin
      step();
      i_sc_finish = 1'b0;
      chk("wait_no_done", 450'(o_done), 450'(0));
      chk("start_once", 450'(o_sc_start), 450'(0));
      chk("busy_wait", 450'(o_busy), 450'(1));
    end
    i_sc_finish = 1'b1;
    i_sc_score  = sc;
    step();
    i_sc_finish = 1'b0;
    i_sc_score  = $urandom;
    chk("done_onehot", 450'(o_done), 450'(4'(1) << k));
    chk("score", 450'($unsigned(o_score)), 450'(sc));
    chk("timeout_clr", 450'(o_timeout), 450'(0));
    chk("board_hold", o_sc_board, eb);
    chk("turn_hold", 450'(o_sc_turn), 450'(et));
  endtask

  initial begin
    int n, k, gap, last;
    bit drop;
    logic [NREQ-1:0] pend, masked;
    checks = 0;
    failures = 0;
    i_rst_n = 1'b0;
    i_req = '0;
    i_board = '0;
    i_turn = '0;
    i_sc_finish = 1'b0;
    i_sc_score = '0;
    repeat (2) step();
    chk("rst_done", 450'(o_done), 450'(0));
    chk("rst_score", 450'($unsigned(o_score)), 450'(0));
    chk("rst_start", 450'(o_sc_start), 450'(0));
    chk("rst_board", o_sc_board, 450'(0));
    chk("rst_turn", 450'(o_sc_turn), 450'(0));
    chk("rst_busy", 450'(o_busy), 450'(0));
    chk("rst_timeout", 450'(o_timeout), 450'(0));
    i_rst_n = 1'b1;
    last = NREQ - 1;

    // Stray finish while idle
    i_sc_finish = 1'b1;
    i_sc_score = 32'd77;
    step();
    i_sc_finish = 1'b0;
    chk("idle_fin_done", 450'(o_done), 450'(0));
    step();
    chk("idle_fin_done2", 450'(o_done), 450'(0));
    chk("idle_fin_busy", 450'(o_busy), 450'(0));

    // Single request, finish 5 cycles after start, plus a finish during S_START
    for (int j = 0; j < NREQ; j++) i_board[j*450 +: 450] = rand450();
    i_turn = 4'b1010;
    i_req = 4'b0010;
    run_one(1, 1, 5, 32'd123, 1'b1, 1'b0);
    last = 1;

    // Requester 2 held through the masked cycle, requester 3 idle
    i_req = 4'b0100;
    run_one(2, 2, 2, 32'hFFFF_FFF9, 1'b0, 1'b0);
    last = 2;
    run_one(2, 3, 3, 32'd55, 1'b0, 1'b0);
    last = 2;
    i_req = '0;

    // All requests held from reset: 0,1,2,3,0
    i_rst_n = 1'b0;
    step();
    i_req = '1;
    i_rst_n = 1'b1;
    run_one(0, 1, 2, 32'd10, 1'b0, 1'b0);
    for (int g = 1; g <= NREQ; g++) begin
      run_one(g % NREQ, 2, 1 + g, 32'd10 + 32'(g), 1'b0, 1'b0);
    end
    last = 0;

    // Randomized traffic
    pend = '1;
    for (int t = 0; t < 40; t++) begin
      pend |= NREQ'($urandom) & NREQ'($urandom);
      if (pend == '0) pend[$urandom_range(0, NREQ - 1)] = 1'b1;
      i_req = pend;
      for (int j = 0; j < NREQ; j++) i_board[j*450 +: 450] = rand450();
      i_turn = NREQ'($urandom);
      masked = pend & ~(4'(1) << last);
      if (masked != '0) begin
        k = rr_pick(masked, last);
        gap = 2;
      end else begin
        k = last;
        gap = 3;
      end
      drop = ($urandom_range(0, 3) == 0);
      run_one(k, gap, $urandom_range(1, 6), $urandom, 1'b0, drop);
      pend[k] = (!drop && ($urandom_range(0, 3) == 0)) ? 1'b1 : 1'b0;
      i_req = pend;
      last = k;
    end

    // Reset during S_WAIT abandons the evaluation
    i_req = 4'b1000;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_sc_start && n < 20);
    chk("rstwait_start", 450'(o_sc_start), 450'(1));
    i_req = '0;
    step();
    chk("rstwait_busy", 450'(o_busy), 450'(1));
    i_rst_n = 1'b0;
    #1;
    chk("rstwait_busy0", 450'(o_busy), 450'(0));
    chk("rstwait_board0", o_sc_board, 450'(0));
    chk("rstwait_start0", 450'(o_sc_start), 450'(0));
    chk("rstwait_done0", 450'(o_done), 450'(0));
    step();
    i_rst_n = 1'b1;
    i_sc_finish = 1'b1;
    i_sc_score = 32'd5;
    step();
    i_sc_finish = 1'b0;
    chk("rstwait_nodone", 450'(o_done), 450'(0));
    step();
    chk("rstwait_nodone2", 450'(o_done), 450'(0));
    chk("rstwait_idle", 450'(o_busy), 450'(0));

    // Score unit never answers
    i_req = 4'b0001;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_sc_start && n < 20);
    chk("to_start", 450'(n), 450'(1));
    i_req = '0;
`ifdef SCORE_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      step();
      chk("to_pending", 450'(o_done), 450'(0));
      chk("to_flag_low", 450'(o_timeout), 450'(0));
    end
    step();
    chk("to_done", 450'(o_done), 450'(4'b0001));
    chk("to_flag", 450'(o_timeout), 450'(1));
    chk("to_score", 450'($unsigned(o_score)), 450'(32'h8000_0001));
    step();
    chk("to_done_clr", 450'(o_done), 450'(0));
    chk("to_flag_clr", 450'(o_timeout), 450'(0));
`else
    for (int c = 1; c <= 3 * TO; c++) begin
      step();
      chk("nto_pending", 450'(o_done), 450'(0));
      chk("nto_flag", 450'(o_timeout), 450'(0));
    end
    i_sc_finish = 1'b1;
    i_sc_score = 32'd99;
    step();
    i_sc_finish = 1'b0;
    chk("nto_done", 450'(o_done), 450'(4'b0001));
    chk("nto_score", 450'($unsigned(o_score)), 450'(32'd99));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_arbiter.md
SCORE_ARBITER -- requirements
Module: score_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesting Minmax leaf nodes (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum S_WAIT cycles before abort (used only with SCORE_ARB_TIMEOUT_EN).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  NREQ  level request per requester, held until its o_done.
REQ-006 SHALL have port i_board  input  NREQ*450  requester k board at bits [450k+449:450k]; cell c at bits [2c+1:2c].
REQ-007 SHALL have port i_turn  input  NREQ  side to evaluate per requester.
REQ-008 SHALL have port o_done  output  NREQ  one-cycle completion pulse, one-hot, served requester only.
REQ-009 SHALL have port o_score  output  32 signed  result; valid only while o_done nonzero.
REQ-010 SHALL have port o_sc_start  output  1  one-cycle start pulse to shared Score unit.
REQ-011 SHALL have port o_sc_board  output  450  latched board of granted requester.
REQ-012 SHALL have port o_sc_turn  output  1  latched turn of granted requester.
REQ-013 SHALL have port i_sc_finish  input  1  Score unit completion pulse.
REQ-014 SHALL have port i_sc_score  input  32 signed  Score unit result, valid with i_sc_finish.
REQ-015 SHALL have port o_busy  output  1  high in every state except S_IDLE.
REQ-016 SHALL have port o_timeout  output  1  abort flag, pulses with o_done.

Function
REQ-017 SHALL implement FSM S_IDLE, S_START, S_WAIT, S_DONE; all outputs registered.
REQ-018 In S_IDLE with any unmasked request, SHALL grant round-robin starting at (last_grant+1) mod NREQ, latch board/turn/grant index, go to S_START.
REQ-019 S_START SHALL assert o_sc_start for exactly one cycle, then go to S_WAIT.
REQ-020 S_WAIT SHALL capture i_sc_score on i_sc_finish and go to S_DONE; i_sc_finish in any other state SHALL be ignored.
REQ-021 S_DONE SHALL assert o_done[grant] and o_score for one cycle, set last_grant=grant, return to S_IDLE.
REQ-022 Just-served requester SHALL be masked for the first S_IDLE cycle after S_DONE; other requesters are eligible in that cycle.
REQ-023 Latency: req seen in S_IDLE cycle t -> o_sc_start at t+1; i_sc_finish at cycle f -> o_done at f+1.
REQ-024 i_req/i_board/i_turn changes after grant SHALL NOT affect the in-flight evaluation (latched values used).
REQ-025 Requester dropping i_req while granted SHALL still receive o_done; no cancellation.
REQ-026 o_sc_board/o_sc_turn SHALL hold stable from S_START until next grant.
REQ-027 Grant index width SHALL be $clog2(NREQ); round-robin wrap NREQ-1 -> 0.

Reset
REQ-028 Asynchronous reset SHALL force S_IDLE; o_done=0, o_score=0, o_sc_start=0, o_sc_board=0, o_sc_turn=0, o_busy=0, o_timeout=0, last_grant=NREQ-1, no mask.
REQ-029 Reset mid-evaluation SHALL abandon it with no o_done; a subsequent i_sc_finish while S_IDLE SHALL be ignored.

Configuration
REQ-030 Macro SCORE_ARB_TIMEOUT_EN defined: S_WAIT cycle counter; after TIMEOUT cycles without i_sc_finish, o_score=32'h80000001 (MINN), o_timeout=1 with o_done, go to S_DONE.
REQ-031 Macro SCORE_ARB_TIMEOUT_EN undefined: no counter, S_WAIT waits indefinitely, o_timeout tied 0.

Verification
REQ-032 Single request: i_req=4'b0010, finish 5 cycles after start with score 123 -> o_sc_start once, o_done=4'b0010 with o_score=123 one cycle after finish.
REQ-033 All requests held, NREQ=4, out of reset -> grant order 0,1,2,3,0; each o_done one-hot.
REQ-034 Requester 2 keeps i_req high for one cycle after o_done, requester 3 idle -> no re-grant to 2 in masked cycle; re-granted next cycle.
REQ-035 Assert i_sc_finish during S_START and S_IDLE -> ignored; o_done only after finish in S_WAIT.
REQ-036 Reset asserted in S_WAIT -> outputs at reset values immediately; later i_sc_finish produces no o_done.
REQ-037 SCORE_ARB_TIMEOUT_EN, TIMEOUT=16, no finish -> o_done and o_timeout 17 cycles after o_sc_start, o_score=32'h80000001.
